// File: rtl/dma_pkg.sv
// Shared widths, state encoding and memory request payload for the stream DMA master.
package dma_pkg;

    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 18;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        READ,
        WRITE,
        FIN
    } dma_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } mem_req_t;

endpackage

// File: rtl/dma_result_fifo.sv
// Small synchronous FIFO holding processed words until they are written back.
module dma_result_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_stream_master.sv
// DMA initiator: reads a frame into the filter core and writes its results back.
module dma_stream_master
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_dat_o,
    input  logic [DATA_W-1:0] mem_dat_i,
    input  logic              mem_ack,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    input  logic              pix_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready
);

    dma_state_t            state_q, state_d;
    mem_req_t              mem_req_q;
    logic [ADDR_W-1:0]     rd_adr_q, wr_adr_q;
    logic [CNT_W-1:0]      rd_cnt_q, wr_cnt_q, n_q;
    logic [DATA_W-1:0]     fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  start_acc_c, rd_ack_c, wr_ack_c, pix_free_c, unused_bits_c;

    assign start_acc_c   = (state_q == IDLE) && start;
    assign rd_ack_c      = (state_q == READ) && mem_ack;
    assign wr_ack_c      = (state_q == WRITE) && mem_ack;
    assign pix_free_c    = !pix_valid || pix_ready;
    assign res_ready     = rst && !fifo_full;
    assign unused_bits_c = ^{src_base[1:0], dst_base[1:0], fifo_count};

    assign mem_we    = mem_req_q.we;
    assign mem_adr_o = mem_req_q.adr;
    assign mem_dat_o = mem_req_q.dat;

    dma_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (state_q == FIN),
        .push      (res_valid && res_ready),
        .push_data (res_data),
        .pop       (wr_ack_c),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Writes drain first so the result FIFO never backs up the core longer than needed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (word_count == '0) ? FIN : ARB;
            end
            ARB: begin
                if (!fifo_empty && (wr_cnt_q < n_q))     state_d = WRITE;
                else if ((rd_cnt_q < n_q) && pix_free_c) state_d = READ;
                else if (wr_cnt_q == n_q)                state_d = FIN;
            end
            READ, WRITE: begin
                if (mem_ack) state_d = ARB;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            rd_adr_q  <= '0;
            wr_adr_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_stb   <= 1'b0;
            mem_req_q <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_q == FIN);
            mem_stb <= (state_d == READ) || (state_d == WRITE);

            if (start_acc_c) begin
                rd_adr_q <= {src_base[ADDR_W-1:2], 2'b00};
                wr_adr_q <= {dst_base[ADDR_W-1:2], 2'b00};
                n_q      <= word_count;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
            end

            // Request fields are frozen for the whole strobe.
            if (state_q == ARB && state_d == READ) begin
                mem_req_q.we  <= 1'b0;
                mem_req_q.adr <= rd_adr_q;
            end
            if (state_q == ARB && state_d == WRITE) begin
                mem_req_q.we  <= 1'b1;
                mem_req_q.adr <= wr_adr_q;
                mem_req_q.dat <= fifo_head;
            end

            if (rd_ack_c) begin
                rd_adr_q <= rd_adr_q + ADDR_W'(WORD_BYTES);
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                pix_data <= mem_dat_i;
            end
            if (wr_ack_c) begin
                wr_adr_q <= wr_adr_q + ADDR_W'(WORD_BYTES);
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end

            if (rd_ack_c)                    pix_valid <= 1'b1;
            else if (pix_valid && pix_ready) pix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_stream_master.sv
// Bench for dma_stream_master: memory responder, echoing filter core and write-back scoreboard.
module tb_dma_stream_master;
    import dma_pkg::*;

    logic              clk, rst, start;
    logic [ADDR_W-1:0] src_base, dst_base;
    logic [CNT_W-1:0]  word_count;
    logic              busy, done, mem_stb, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_adr_o;
    logic [DATA_W-1:0] mem_dat_o, mem_dat_i;
    logic              pix_valid, pix_ready, res_valid, res_ready;
    logic [DATA_W-1:0] pix_data, res_data;

    dma_stream_master dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .word_count(word_count), .busy(busy), .done(done), .mem_stb(mem_stb), .mem_we(mem_we),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack(mem_ack),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } wr_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [CNT_W-1:0]  n;
        int rd_wait, wr_wait, pix_mode, stall, busy_start_at;
        int exp_xfers, exp_first_stb, exp_done_cyc, exp_last_rd, exp_last_wr, exp_full;
    } vec_t;

    wr_exp_t           sb_q[$];
    logic [DATA_W-1:0] core_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc, first_stb, stb_cycles, n_rd, n_wr;
    int rd_wait, wr_wait, pix_mode, stall;
    bit hold, saw_full, snap_we;
    logic [ADDR_W-1:0] exp_rd_adr, exp_wr_adr, last_rd_adr, last_wr_adr, snap_adr;
    logic [DATA_W-1:0] snap_dat;
    vec_t vecs[6];

    function automatic logic [DATA_W-1:0] src_word(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                                input logic [CNT_W-1:0] n, input int rw, input int ww, input int pm,
                                input int st, input int bs, input int ex, input int fs, input int dc,
                                input int lr, input int lw, input int fu);
        vec_t v;
        v.src = src; v.dst = dst; v.n = n; v.rd_wait = rw; v.wr_wait = ww; v.pix_mode = pm;
        v.stall = st; v.busy_start_at = bs; v.exp_xfers = ex; v.exp_first_stb = fs;
        v.exp_done_cyc = dc; v.exp_last_rd = lr; v.exp_last_wr = lw; v.exp_full = fu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_bench();
        sb_q.delete();
        core_q.delete();
        stb_cycles = 0;
        hold       = (stall > 0);
        saw_full   = 1'b0;
        n_rd       = 0;
        n_wr       = 0;
        first_stb  = -1;
    endtask

    // One clock: observe settled outputs on the falling edge, drive inputs for the next rising edge.
    task automatic tick();
        wr_exp_t e;
        @(negedge clk);
        cyc++;
        if (mem_stb) begin
            stb_cycles++;
            if (first_stb < 0) first_stb = cyc - start_cyc;
            if (stb_cycles == 1) begin
                snap_we = mem_we; snap_adr = mem_adr_o; snap_dat = mem_dat_o;
            end else begin
                check("stb_hold_we", 32'(mem_we), 32'(snap_we));
                check("stb_hold_adr", 32'(mem_adr_o), 32'(snap_adr));
                if (snap_we) check("stb_hold_dat", mem_dat_o, snap_dat);
            end
            mem_ack = (stb_cycles > (mem_we ? wr_wait : rd_wait));
            if (mem_ack) begin
                if (!mem_we) begin
                    check("rd_adr", 32'(mem_adr_o), 32'(exp_rd_adr));
                    mem_dat_i = src_word(mem_adr_o);
                    e.adr = exp_wr_adr;
                    e.dat = src_word(exp_rd_adr) + 32'd1;
                    sb_q.push_back(e);
                    last_rd_adr = mem_adr_o;
                    exp_rd_adr += ADDR_W'(4);
                    exp_wr_adr += ADDR_W'(4);
                    n_rd++;
                end else begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL wr_unexpected: write to 0x%0h data 0x%0h with empty scoreboard", mem_adr_o, mem_dat_o);
                    end else begin
                        e = sb_q.pop_front();
                        check("wr_adr", 32'(mem_adr_o), 32'(e.adr));
                        check("wr_dat", mem_dat_o, e.dat);
                    end
                    last_wr_adr = mem_adr_o;
                    n_wr++;
                end
                stb_cycles = 0;
            end else begin
                mem_dat_i = $urandom;
            end
        end else begin
            stb_cycles = 0;
            mem_ack    = ($urandom_range(0, 3) == 0);
            mem_dat_i  = $urandom;
        end
        if (hold && core_q.size() >= stall) hold = 1'b0;
        if (core_q.size() > 0 && !hold) begin
            res_valid = 1'b1;
            res_data  = core_q[0];
            if (res_ready) void'(core_q.pop_front());
        end else begin
            res_valid = 1'b0;
            res_data  = $urandom;
        end
        pix_ready = (pix_mode == 0) ? 1'b1 : cyc[0];
        if (pix_valid && pix_ready) core_q.push_back(pix_data + 32'd1);
        if (!res_ready && rst && busy) saw_full = 1'b1;
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int got, busy_low, done_cyc, idle_bad;
        bit busy_at_done;
        rd_wait = v.rd_wait; wr_wait = v.wr_wait; pix_mode = v.pix_mode; stall = v.stall;
        clr_bench();
        exp_rd_adr = {v.src[ADDR_W-1:2], 2'b00};
        exp_wr_adr = {v.dst[ADDR_W-1:2], 2'b00};
        src_base = v.src; dst_base = v.dst; word_count = v.n;
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        got = 0; busy_low = 0; done_cyc = -1; busy_at_done = 1'b1;
        for (int i = 1; i < 3000 && got == 0; i++) begin
            if (v.busy_start_at == i) begin
                src_base = '0; word_count = CNT_W'(5); start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                got = 1; done_cyc = cyc - start_cyc; busy_at_done = busy;
            end else if (!busy) busy_low++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        if (v.exp_done_cyc >= 0) check({tag, "_done_latency"}, 32'(done_cyc), 32'(v.exp_done_cyc));
        check({tag, "_reads"}, 32'(n_rd), 32'(v.exp_xfers));
        check({tag, "_writes"}, 32'(n_wr), 32'(v.exp_xfers));
        check({tag, "_first_stb"}, 32'(first_stb), 32'(v.exp_first_stb));
        if (v.exp_last_rd >= 0) check({tag, "_last_rd"}, 32'(last_rd_adr), 32'(v.exp_last_rd));
        if (v.exp_last_wr >= 0) check({tag, "_last_wr"}, 32'(last_wr_adr), 32'(v.exp_last_wr));
        if (v.exp_full >= 0) check({tag, "_fifo_full"}, 32'(saw_full), 32'(v.exp_full));
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_core_empty"}, 32'(core_q.size()), 32'd0);
        idle_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_stb || busy || done) idle_bad++;
        end
        check({tag, "_idle_after"}, 32'(idle_bad), 32'd0);
    endtask

    initial begin
        int found, bad;
        rst = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; word_count = '0;
        mem_ack = 1'b0; mem_dat_i = '0; pix_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        rd_wait = 0; wr_wait = 0; pix_mode = 0; stall = 0;
        clr_bench();

        //        src        dst        n   rw ww pm st bs  ex fs  dc  last_rd    last_wr   full
        vecs[0] = mk(22'h0,      22'h40000, 18'd8, 0, 0, 0, 0, 0, 8, 2, -1, 'h1C,    'h4001C, -1);
        vecs[1] = mk(22'h100,    22'h40100, 18'd8, 3, 3, 1, 0, 0, 8, 2, -1, 'h11C,   'h4011C, -1);
        vecs[2] = mk(22'h200,    22'h40200, 18'd8, 0, 3, 0, 4, 0, 8, 2, -1, 'h21C,   'h4021C,  1);
        vecs[3] = mk(22'h3,      22'h1002,  18'd3, 1, 0, 1, 0, 0, 3, 2, -1, 'h8,     'h1008,  -1);
        vecs[4] = mk(22'h500,    22'h600,   18'd0, 0, 0, 0, 0, 0, 0, -1, 2, -1,      -1,       0);
        vecs[5] = mk(22'h3FFFFC, 22'h80,    18'd2, 0, 0, 0, 0, 3, 2, 2, -1, 'h0,     'h84,    -1);

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_stb", 32'(mem_stb), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_adr", 32'(mem_adr_o), 32'd0);
        check("rst_mem_dat", mem_dat_o, 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", pix_data, 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_res_ready", 32'(res_ready), 32'd1);

        for (int k = 0; k < 6; k++) run_xfer(vecs[k], $sformatf("vec%0d", k));

        // Abort with reset while the fifth read of a 16-word frame is outstanding.
        rd_wait = 3; wr_wait = 0; pix_mode = 0; stall = 0;
        clr_bench();
        exp_rd_adr = 22'h1000; exp_wr_adr = 22'h2000;
        src_base = 22'h1000; dst_base = 22'h2000; word_count = 18'd16;
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (mem_stb && !mem_we && n_rd == 4) found = 1;
        end
        check("abort_reached_5th_read", 32'(found), 32'd1);
        rst = 1'b0;
        tick();
        check("abort_mem_stb", 32'(mem_stb), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pix_valid", 32'(pix_valid), 32'd0);
        check("abort_res_ready", 32'(res_ready), 32'd0);
        tick();
        rst = 1'b1;
        clr_bench();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || mem_stb || busy) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);
        run_xfer(mk(22'h1000, 22'h2000, 18'd2, 0, 0, 0, 0, 0, 2, 2, -1, 'h1004, 'h2004, -1), "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
